// File: rtl/servo_pkg.sv
// Servo PWM generator shared definitions.
// Parameter defaults, FSM state type and pulse-width helper.
package servo_pkg;

  localparam int DEF_PERIOD_CYCLES = 200_000;
  localparam int DEF_MIN_PULSE     = 10_000;
  localparam int DEF_SCALE         = 39;
  localparam int DEF_STEP_MAX      = 4;
  localparam int DEF_POS_MAX       = 255;

  localparam int CNT_W = 18;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    DISABLED,
    HIGH,
    LOW
  } state_t;

  function automatic cnt_t pulse_width(
    input logic [7:0] pos,
    input int         min_pulse,
    input int         scale
  );
    return cnt_t'(min_pulse) + cnt_t'(pos) * cnt_t'(scale);
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Servo position slew limiter.
// Clamps the target and moves the applied position at most STEP_MAX per frame.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int STEP_MAX = DEF_STEP_MAX,
  parameter int POS_MAX  = DEF_POS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target,
  input  logic [7:0] cur_pos,
  input  logic       update,
  input  logic       enable,
  output logic [7:0] next_pos
);

  localparam logic [8:0] STEP = 9'(STEP_MAX);
  localparam logic [8:0] PMAX = 9'(POS_MAX);

  logic [8:0] tgt;
  logic [8:0] cur;
  logic [8:0] diff;
  logic [8:0] step;
  logic [7:0] nxt;

  // Clamp the target and compute the rate-limited move without wrap.
  always_comb begin
    tgt  = {1'b0, target};
    cur  = {1'b0, cur_pos};
    diff = '0;
    step = '0;
    nxt  = cur_pos;
    if (tgt > PMAX)
      tgt = PMAX;
    if (tgt > cur) begin
      diff = tgt - cur;
      step = (diff < STEP) ? diff : STEP;
      nxt  = 8'(cur + step);
    end else if (tgt < cur) begin
      diff = cur - tgt;
      step = (diff < STEP) ? diff : STEP;
      nxt  = 8'(cur - step);
    end
  end

  // Applied position only moves at a frame boundary while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      next_pos <= '0;
    else if (update && enable)
      next_pos <= nxt;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator.
// Fixed frame, slew-limited position, registered glitch-free pulse.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int MIN_PULSE     = DEF_MIN_PULSE,
  parameter int SCALE         = DEF_SCALE,
  parameter int STEP_MAX      = DEF_STEP_MAX,
  parameter int POS_MAX       = DEF_POS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] position,
  input  logic       enable,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_pos
);

  if (MIN_PULSE + POS_MAX * SCALE >= PERIOD_CYCLES ||
      STEP_MAX < 1 || POS_MAX > 255 || POS_MAX < 0 ||
      PERIOD_CYCLES > (1 << CNT_W) || MIN_PULSE < 1) begin : g_bad_params
    $error("servo_pwm_gen: illegal parameter set");
  end

  localparam cnt_t LAST = cnt_t'(PERIOD_CYCLES - 1);

  cnt_t   period_cnt;
  cnt_t   cnt_next;
  cnt_t   pw;
  logic   started;
  logic   boundary;
  state_t state;
  state_t state_next;

  // The first edge after reset opens a frame without advancing the count.
  assign boundary = !started || (period_cnt == LAST);
  assign cnt_next = boundary ? '0 : period_cnt + cnt_t'(1);
  assign pw       = pulse_width(cur_pos, MIN_PULSE, SCALE);

  // Frame counter and frame-start strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt  <= '0;
      started     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      period_cnt  <= cnt_next;
      started     <= 1'b1;
      frame_start <= boundary;
    end
  end

  // State register; pwm_out follows next state so it aligns with period_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DISABLED;
      pwm_out <= 1'b0;
    end else begin
      state   <= state_next;
      pwm_out <= (state_next == HIGH);
    end
  end

  // Next state from the upcoming count value.
  always_comb begin
    state_next = state;
    if (boundary) begin
      state_next = enable ? HIGH : DISABLED;
    end else begin
      unique case (state)
        HIGH:     if (cnt_next >= pw) state_next = LOW;
        LOW:      state_next = LOW;
        DISABLED: state_next = DISABLED;
        default:  state_next = DISABLED;
      endcase
    end
  end

  servo_slew_limiter #(
    .STEP_MAX (STEP_MAX),
    .POS_MAX  (POS_MAX)
  ) u_slew (
    .clk      (clk),
    .reset    (reset),
    .target   (position),
    .cur_pos  (cur_pos),
    .update   (boundary),
    .enable   (enable),
    .next_pos (cur_pos)
  );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with scaled-down frame parameters.
// Stimulus queues per-frame expectations; a monitor measures each frame.
module tb_servo_pwm_gen;

  localparam int P  = 500;
  localparam int MP = 50;
  localparam int SC = 5;
  localparam int SM = 4;
  localparam int PM = 42;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] position = 8'd0;
  logic       pwm_out;
  logic       frame_start;
  logic [7:0] cur_pos;

  servo_pwm_gen #(
    .PERIOD_CYCLES (P),
    .MIN_PULSE     (MP),
    .SCALE         (SC),
    .STEP_MAX      (SM),
    .POS_MAX       (PM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .position    (position),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .cur_pos     (cur_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cur;
    int pw;
  } exp_t;

  typedef struct {
    int pos;
    bit en;
    int off;
    int cur;
    int pw;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // pw = 50 + 5*cur; target clamps at 42; step 4
  vec_t tbl [22] = '{
    '{0,   1'b1, 20,  0,  50},
    '{20,  1'b1, 20,  4,  70},
    '{20,  1'b1, 20,  8,  90},
    '{20,  1'b1, 20, 12, 110},
    '{20,  1'b1, 20, 16, 130},
    '{20,  1'b1, 20, 20, 150},
    '{20,  1'b1, 20, 20, 150},
    '{255, 1'b1, 20, 24, 170},
    '{255, 1'b1, 20, 28, 190},
    '{255, 1'b1, 20, 32, 210},
    '{255, 1'b1, 20, 36, 230},
    '{255, 1'b1, 20, 40, 250},
    '{255, 1'b1, 20, 42, 260},
    '{255, 1'b1, 20, 42, 260},
    '{0,   1'b1, 20, 38, 240},
    '{43,  1'b1, 20, 42, 260},
    '{0,   1'b0, 250, 42,  0},
    '{0,   1'b0, 100, 42,  0},
    '{10,  1'b1, 100, 38, 240},
    '{10,  1'b1, 20, 34, 220},
    '{33,  1'b1, 20, 33, 215},
    '{33,  1'b1, 20, 33, 215}
  };

  task automatic vec(input int pos, input bit en, input int off,
                     input int ec, input int epw);
    exp_t e;
    repeat (off) @(negedge clk);
    #1;
    position = 8'(pos);
    enable   = en;
    e.cur = ec;
    e.pw  = epw;
    q.push_back(e);
    repeat (P - off) @(negedge clk);
  endtask

  initial begin : monitor
    bit   in_frame;
    bit   seen_low;
    bit   glitch;
    bit   moved;
    int   len;
    int   high;
    int   cap;
    exp_t e;
    in_frame = 1'b0;
    seen_low = 1'b0;
    glitch   = 1'b0;
    moved    = 1'b0;
    len      = 0;
    high     = 0;
    cap      = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (in_frame && q.size() > 0)
          void'(q.pop_front());
        in_frame = 1'b0;
      end else if (frame_start) begin
        if (in_frame) begin
          if (q.size() == 0) begin
            chk("exp_queue_underflow", 1, 0);
          end else begin
            e = q.pop_front();
            chk("frame_cur_pos", cap, e.cur);
            chk("pulse_width", high, e.pw);
            chk("pulse_glitch", int'(glitch), 0);
            chk("frame_len", len, P);
            chk("cur_pos_stable", int'(moved), 0);
          end
        end
        in_frame = 1'b1;
        len      = 1;
        high     = pwm_out ? 1 : 0;
        seen_low = !pwm_out;
        glitch   = 1'b0;
        moved    = 1'b0;
        cap      = int'(cur_pos);
      end else if (in_frame) begin
        len++;
        if (int'(cur_pos) != cap)
          moved = 1'b1;
        if (pwm_out) begin
          if (seen_low)
            glitch = 1'b1;
          high++;
        end else begin
          seen_low = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    reset    = 1'b1;
    position = 8'd0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_cur_pos", int'(cur_pos), 0);
    e.cur = 0;
    e.pw  = 50;
    q.push_back(e);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_pwm_high", int'(pwm_out), 1);

    foreach (tbl[i])
      vec(tbl[i].pos, tbl[i].en, tbl[i].off, tbl[i].cur, tbl[i].pw);

    repeat (30) @(negedge clk);
    chk("pwm_before_reset", int'(pwm_out), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_pwm_out", int'(pwm_out), 0);
    chk("async_reset_cur_pos", int'(cur_pos), 0);
    chk("async_reset_frame_start", int'(frame_start), 0);
    position = 8'd8;
    enable   = 1'b1;
    e.cur = 4;
    e.pw  = 70;
    q.push_back(e);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_frame_start", int'(frame_start), 1);
    chk("post_reset_cur_pos", int'(cur_pos), 4);
    chk("post_reset_pwm_high", int'(pwm_out), 1);

    vec(8, 1'b1, 20, 8, 90);
    repeat (P) @(negedge clk);
    #2;
    chk("exp_queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
